// File: rtl/fp6_result_normalizer_if.sv
// Handshake bundle between an FP6 adder and the result normalizer.
// The master drives results in and takes normalized results out; the slave is the normalizer.
interface fp6_result_normalizer_if;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] in_data;
   logic       in_ovf;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] out_data;
   logic [1:0] out_flags;

   modport master (
      output in_valid, in_data, in_ovf, out_ready,
      input  in_ready, out_valid, out_data, out_flags
   );

   modport slave (
      input  in_valid, in_data, in_ovf, out_ready,
      output in_ready, out_valid, out_data, out_flags
   );
endinterface

// File: rtl/fp6_result_normalizer.sv
// FP6 adder-result normalizer: saturates on overflow, shifts subnormal-looking results left.
// Define FP6_NORM_FIFO_EN for a FIFO_DEPTH-entry output FIFO; otherwise the output buffer is one entry.
module fp6_result_normalizer #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic                   clk,
   input logic                   rst,
   fp6_result_normalizer_if.slave bus
);

`ifdef FP6_NORM_FIFO_EN
   localparam int unsigned DEPTH = FIFO_DEPTH;
`else
   localparam int unsigned DEPTH = 1;
`endif
   // Storage is declared at FIFO_DEPTH; with DEPTH=1 the pointers never leave entry 0.
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, EMIT} state_t;

   state_t        state_q, state_d;
   logic [1:0]    e_q, e_d;
   logic [3:0]    m_q, m_d;
   logic [1:0]    flags_q, flags_d;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [7:0]    head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          full, push, pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full = (count == CW'(DEPTH));
   assign pop  = bus.out_valid & bus.out_ready;
   assign push = (state_q == EMIT) & (~full | pop);

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      e_d     = e_q;
      m_d     = m_q;
      flags_d = flags_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               e_d = bus.in_data[5:4];
               m_d = bus.in_data[3:0];
               state_d = EMIT;
               if (bus.in_ovf) begin
                  e_d     = 2'b11;
                  m_d     = 4'b1111;
                  flags_d = 2'b01;
               end else if (bus.in_data[3:0] == 4'd0) begin
                  e_d     = 2'b00;
                  flags_d = 2'b10;
               end else if (bus.in_data[3] || bus.in_data[5:4] == 2'd0) begin
                  flags_d = {(bus.in_data[5:4] == 2'd0) & ~bus.in_data[3], 1'b0};
               end else begin
                  flags_d = 2'b00;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            m_d     = {m_q[2:0], 1'b0};
            e_d     = e_q - 2'd1;
            flags_d = {~m_d[3], 1'b0};
            if (m_d[3] || e_d == 2'd0) state_d = EMIT;
         end
         EMIT: begin
            if (push) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         e_q     <= 2'd0;
         m_q     <= 4'd0;
         flags_q <= 2'd0;
      end else begin
         state_q <= state_d;
         e_q     <= e_d;
         m_q     <= m_d;
         flags_q <= flags_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: buffer storage has no reset; the count and pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {e_q, m_q, flags_q};
   end

   assign head          = mem[rd_ptr];
   assign bus.in_ready  = (state_q == IDLE) & ~rst;
   assign bus.out_valid = (count != '0);
   assign bus.out_data  = bus.out_valid ? head[7:2] : 6'd0;
   assign bus.out_flags = bus.out_valid ? head[1:0] : 2'd0;

endmodule

// File: doc/fp6_result_normalizer.md
FP6_RESULT_NORMALIZER -- requirements
Module: fp6_result_normalizer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of output buffer entries (power of two, >=2; used only with FP6_NORM_FIFO_EN).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  adder result present on in_data/in_ovf.
REQ-005 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port in_data  input  6  adder result; [5:4] exponent E (unsigned), [3:0] mantissa M.
REQ-007 SHALL have port in_ovf  input  1  adder exponent-increment overflow for this result.
REQ-008 SHALL have port out_valid  output  1  normalized result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-010 SHALL have port out_data  output  6  normalized result, same field layout as in_data.
REQ-011 SHALL have port out_flags  output  2  [0] saturated, [1] not normalized (zero or subnormal).

Function
REQ-012 SHALL transfer input on a cycle with in_valid & in_ready, and output on a cycle with out_valid & out_ready.
REQ-013 SHALL implement FSM states IDLE, SHIFT, EMIT; in_ready = 1 only in IDLE.
REQ-014 IDLE, on accept: in_ovf=1 -> result 6'b111111, flags 2'b01, go EMIT; else M=0 -> result 6'b000000, flags 2'b10, go EMIT; else M[3]=1 or E=0 -> result unchanged, flags {E=0 & M[3]=0, 0}, go EMIT; else load working E/M, go SHIFT.
REQ-015 SHIFT: each cycle M <= M<<1, E <= E-1; leave for EMIT when the updated M[3]=1 or updated E=0; max 3 SHIFT cycles.
REQ-016 SHIFT exit flags: [1] = (final M[3]=0), [0] = 0; in_ovf takes priority over every other rule.
REQ-017 EMIT: write {result, flags} to output buffer when not full, or when full and a pop occurs the same cycle; then go IDLE; otherwise hold EMIT with result stable.
REQ-018 Latency accept-to-out_valid SHALL be 2 + shift count cycles with empty buffer and no backpressure.
REQ-019 Output buffer SHALL be FIFO order; occupancy counter 0..FIFO_DEPTH; out_valid = (count != 0); simultaneous push and pop leaves count unchanged.
REQ-020 Read/write pointers SHALL wrap modulo FIFO_DEPTH without loss or duplication.
REQ-021 out_data/out_flags SHALL reflect the head entry and stay stable while out_valid & !out_ready.

Reset
REQ-022 rst SHALL immediately force state IDLE, count 0, pointers 0, out_valid 0, out_data 6'b000000, out_flags 2'b00, in_ready 0 while rst asserted.
REQ-023 Reset mid-SHIFT or mid-EMIT SHALL discard the in-flight result and all buffered entries; in_ready = 1 on the first clock edge after deassertion.

Configuration
REQ-024 With macro FP6_NORM_FIFO_EN defined, the output buffer SHALL be a FIFO_DEPTH-entry FIFO per REQ-019/020.
REQ-025 Without FP6_NORM_FIFO_EN, the output buffer SHALL be a single register (depth 1), FIFO_DEPTH ignored; full = out_valid; push allowed when empty or popped same cycle.

Verification
REQ-026 in_data=6'b10_1010, in_ovf=0, out_ready=1 -> out_data 6'b10_1010, flags 2'b00, out_valid 2 cycles after accept.
REQ-027 in_data=6'b11_0001 -> 3 SHIFT cycles, out_data 6'b00_1000, flags 2'b00, out_valid 5 cycles after accept.
REQ-028 in_data=6'b01_0011 -> 1 SHIFT, out_data 6'b00_0110, flags 2'b10; in_data=6'b10_0000 -> 6'b000000, flags 2'b10.
REQ-029 in_ovf=1 with in_data=6'b01_0101 -> out_data 6'b111111, flags 2'b01, no SHIFT cycles.
REQ-030 FIFO on, out_ready=0, five direct-pass inputs -> four buffered, fifth held in EMIT, in_ready 0; out_ready=1 -> five results drain in order with no gap or duplicate.
REQ-031 rst pulsed while in SHIFT with two entries buffered -> out_valid 0 same cycle; next accepted 6'b10_1000 emerges as first output.
